// File: rtl/fx2_bridge_pkg.sv
// Shared constants for the Maple Bus to FX2 slave FIFO bridge: FSM encoding,
// default endpoint addresses and FX2 flag polarity.
package fx2_bridge_pkg;

  typedef enum logic [7:0] {
    S_IDLE      = 8'b0000_0001,
    S_SEL_IN    = 8'b0000_0010,
    S_CHK_FULL  = 8'b0000_0100,
    S_WR_SETUP  = 8'b0000_1000,
    S_WR_STROBE = 8'b0001_0000,
    S_PKT_END   = 8'b0010_0000,
    S_RD_SAMPLE = 8'b0100_0000,
    S_RD_STROBE = 8'b1000_0000
  } fsm_state_t;

  localparam logic [1:0] EP_OUT_DEFAULT = 2'b00;
  localparam logic [1:0] EP_IN_DEFAULT  = 2'b10;

  localparam logic FLAG_FULL  = 1'b0;
  localparam logic FLAG_EMPTY = 1'b0;

  // States in which the bridge owns the IN endpoint and drives fdata.
  function automatic logic is_in_state(input fsm_state_t s);
    return (s == S_SEL_IN) || (s == S_CHK_FULL) || (s == S_WR_SETUP) ||
           (s == S_WR_STROBE) || (s == S_PKT_END);
  endfunction

endpackage

// File: rtl/mbus_rx_buffer.sv
// Show-ahead synchronous FIFO holding {marker, data} entries from the bus side.
module mbus_rx_buffer #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fx2_fifo_bridge.sv
// Bridge between the Maple Bus transceiver and the FX2 slave FIFO pins, with
// a receive buffer so bus packets survive a momentarily full IN endpoint.
module fx2_fifo_bridge
  import fx2_bridge_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned RXBUF_DEPTH   = 16,
  parameter logic [1:0]  EP_OUT        = EP_OUT_DEFAULT,
  parameter logic [1:0]  EP_IN         = EP_IN_DEFAULT,
  parameter int unsigned MAX_PKT_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_enable,
  input  logic              rx_write,
  input  logic [DATA_W-1:0] rx_data,
  output logic              tx_enable,
  output logic              tx_valid,
  input  logic              tx_read,
  output logic [DATA_W-1:0] tx_data,
  input  logic              full,
  input  logic              empty,
  inout  wire  [DATA_W-1:0] fdata,
  output logic [1:0]        faddr,
  output logic              sloe,
  output logic              slrd,
  output logic              slwr,
  output logic              pkt_end,
  output logic              rx_overflow,
  input  logic              ovf_clr
);

  localparam int unsigned CNT_W = $clog2(MAX_PKT_WORDS + 1);

  fsm_state_t        state;
  fsm_state_t        nxt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [DATA_W-1:0] fdata_q;
  logic [DATA_W:0]   buf_din;
  logic [DATA_W:0]   buf_dout;
  logic              buf_push;
  logic              buf_pop;
  logic              buf_full;
  logic              buf_empty;
  logic              rx_enable_d;
  logic              rx_fall;
  logic              mk_pend;
  logic              mk_pend_nxt;
  logic              drop;

  mbus_rx_buffer #(
    .WIDTH(DATA_W + 1),
    .DEPTH(RXBUF_DEPTH)
  ) u_rxbuf (
    .clk  (clk),
    .reset(reset),
    .push (buf_push),
    .pop  (buf_pop),
    .din  (buf_din),
    .dout (buf_dout),
    .full (buf_full),
    .empty(buf_empty)
  );

  assign rx_fall   = rx_enable_d & ~rx_enable;
  assign tx_enable = tx_valid;
  assign fdata     = sloe ? fdata_q : 'z;

  // A pending marker blocks new words so it cannot be overtaken by the next packet.
  always_comb begin
    buf_push    = 1'b0;
    buf_din     = {1'b0, rx_data};
    drop        = 1'b0;
    mk_pend_nxt = mk_pend;
    if (mk_pend) begin
      drop = rx_write | rx_fall;
      if (!buf_full) begin
        buf_push    = 1'b1;
        buf_din     = {1'b1, {DATA_W{1'b0}}};
        mk_pend_nxt = 1'b0;
      end
    end else if (rx_write) begin
      if (buf_full) drop = 1'b1;
      else          buf_push = 1'b1;
      if (rx_fall)  mk_pend_nxt = 1'b1;
    end else if (rx_fall) begin
      if (!buf_full) begin
        buf_push = 1'b1;
        buf_din  = {1'b1, {DATA_W{1'b0}}};
      end else begin
        mk_pend_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_enable_d <= 1'b0;
      mk_pend     <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      rx_enable_d <= rx_enable;
      mk_pend     <= mk_pend_nxt;
      rx_overflow <= drop | (rx_overflow & ~ovf_clr);
    end
  end

  always_comb begin
    nxt     = state;
    buf_pop = 1'b0;
    case (state)
      S_IDLE: begin
        if (!buf_empty)                                nxt = S_SEL_IN;
        else if ((empty != FLAG_EMPTY) && !tx_valid)   nxt = S_RD_SAMPLE;
      end
      S_SEL_IN: nxt = S_CHK_FULL;
      S_CHK_FULL: begin
        if (buf_empty) begin
          nxt = S_IDLE;
        end else if (buf_dout[DATA_W]) begin
          buf_pop = 1'b1;
          nxt     = (wr_cnt != '0) ? S_PKT_END : S_IDLE;
        end else if (full != FLAG_FULL) begin
          nxt = S_WR_SETUP;
        end else begin
          nxt = S_IDLE;
        end
      end
      S_WR_SETUP: begin
        buf_pop = 1'b1;
        nxt     = S_WR_STROBE;
      end
      S_WR_STROBE: nxt = S_CHK_FULL;
      S_PKT_END:   nxt = S_IDLE;
      S_RD_SAMPLE: nxt = S_RD_STROBE;
      S_RD_STROBE: nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      faddr    <= EP_OUT;
      sloe     <= 1'b0;
      slrd     <= 1'b1;
      slwr     <= 1'b1;
      pkt_end  <= 1'b1;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      wr_cnt   <= '0;
    end else begin
      state   <= nxt;
      faddr   <= is_in_state(nxt) ? EP_IN : EP_OUT;
      sloe    <= is_in_state(nxt);
      slwr    <= (nxt != S_WR_STROBE);
      slrd    <= (nxt != S_RD_STROBE);
      pkt_end <= (nxt != S_PKT_END);
      if (state == S_WR_STROBE)
        wr_cnt <= (wr_cnt == CNT_W'(MAX_PKT_WORDS - 1)) ? '0 : wr_cnt + 1'b1;
      else if (state == S_PKT_END)
        wr_cnt <= '0;
      if (state == S_RD_SAMPLE) begin
        tx_data  <= fdata;
        tx_valid <= 1'b1;
      end else if (tx_read) begin
        tx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_WR_SETUP) fdata_q <= buf_dout[DATA_W-1:0];
  end

endmodule

// File: tb/tb_fx2_fifo_bridge.sv
// Directed bench for fx2_fifo_bridge with a small FX2 pin model and strobe monitor.
module tb_fx2_fifo_bridge;

  localparam logic [1:0] EP_OUT = 2'b00;
  localparam logic [1:0] EP_IN  = 2'b10;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_enable, rx_write, tx_read, full, empty, ovf_clr;
  logic [7:0] rx_data;
  logic       tx_enable, tx_valid;
  logic [7:0] tx_data;
  wire  [7:0] fdata;
  logic [7:0] fx2_drv;
  logic [1:0] faddr;
  logic       sloe, slrd, slwr, pkt_end, rx_overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] wr_q[$];
  int pkt_cnt   = 0;
  int pkt_after = 0;
  int rd_cnt    = 0;
  int bad_faddr = 0;
  int overlap   = 0;
  int wbase, pbase, rbase;
  logic hit;

  always #5 clk = ~clk;

  assign fdata = sloe ? 8'hzz : fx2_drv;

  fx2_fifo_bridge #(
    .DATA_W(8), .RXBUF_DEPTH(16), .EP_OUT(EP_OUT), .EP_IN(EP_IN), .MAX_PKT_WORDS(4)
  ) dut (
    .clk(clk), .reset(reset), .rx_enable(rx_enable), .rx_write(rx_write),
    .rx_data(rx_data), .tx_enable(tx_enable), .tx_valid(tx_valid),
    .tx_read(tx_read), .tx_data(tx_data), .full(full), .empty(empty),
    .fdata(fdata), .faddr(faddr), .sloe(sloe), .slrd(slrd), .slwr(slwr),
    .pkt_end(pkt_end), .rx_overflow(rx_overflow), .ovf_clr(ovf_clr)
  );

  always @(negedge clk) begin
    if (slwr === 1'b0) begin
      wr_q.push_back(fdata);
      if (faddr !== EP_IN) bad_faddr++;
    end
    if (pkt_end === 1'b0) begin
      pkt_cnt++;
      pkt_after = wr_q.size();
    end
    if (slrd === 1'b0) rd_cnt++;
    if (int'(!slwr) + int'(!slrd) + int'(!pkt_end) > 1) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input int n, input logic [7:0] first, input logic [7:0] inc);
    logic [7:0] d;
    d = first;
    rx_enable = 1'b1;
    step(1);
    for (int i = 0; i < n; i++) begin
      rx_write = 1'b1;
      rx_data  = d;
      step(1);
      d = d + inc;
    end
    rx_write  = 1'b0;
    rx_enable = 1'b0;
    step(1);
  endtask

  task automatic mark();
    wbase = wr_q.size();
    pbase = pkt_cnt;
    rbase = rd_cnt;
  endtask

  initial begin
    reset = 1'b0; rx_enable = 1'b0; rx_write = 1'b0; rx_data = '0;
    tx_read = 1'b0; full = 1'b0; empty = 1'b0; ovf_clr = 1'b0; fx2_drv = 8'h00;
    step(3);
    check("rst_slwr", slwr, 1);
    check("rst_slrd", slrd, 1);
    check("rst_pkt_end", pkt_end, 1);
    check("rst_faddr", faddr, EP_OUT);
    check("rst_sloe", sloe, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ovf", rx_overflow, 0);
    reset = 1'b1;
    step(2);

    // Basic packet with room in the IN endpoint.
    full = 1'b1;
    mark();
    send_pkt(3, 8'h11, 8'h11);
    for (int i = 0; i < 200 && pkt_cnt == pbase; i++) step(1);
    step(5);
    check("p1_nwr", wr_q.size() - wbase, 3);
    check("p1_w0", wr_q[wbase], 8'h11);
    check("p1_w1", wr_q[wbase+1], 8'h22);
    check("p1_w2", wr_q[wbase+2], 8'h33);
    check("p1_npkt", pkt_cnt - pbase, 1);
    check("p1_pkt_after", pkt_after - wbase, 3);
    check("p1_idle_faddr", faddr, EP_OUT);

    // Endpoint full for a while, then space appears.
    full = 1'b0;
    mark();
    send_pkt(3, 8'h11, 8'h11);
    step(20);
    check("p2_nwr_blocked", wr_q.size() - wbase, 0);
    full = 1'b1;
    for (int i = 0; i < 200 && pkt_cnt == pbase; i++) step(1);
    step(5);
    check("p2_nwr", wr_q.size() - wbase, 3);
    check("p2_w0", wr_q[wbase], 8'h11);
    check("p2_w2", wr_q[wbase+2], 8'h33);
    check("p2_npkt", pkt_cnt - pbase, 1);
    check("p2_ovf", rx_overflow, 0);

    // Overflow of the 16-entry buffer.
    full = 1'b0;
    mark();
    rx_enable = 1'b1;
    step(1);
    for (int i = 1; i <= 20; i++) begin
      rx_write = 1'b1;
      rx_data  = 8'(i);
      step(1);
    end
    rx_write = 1'b0;
    check("ov_set", rx_overflow, 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ov_clr", rx_overflow, 0);
    rx_write = 1'b1; rx_data = 8'hEE; ovf_clr = 1'b1;
    step(1);
    rx_write = 1'b0; ovf_clr = 1'b0;
    check("ov_set_wins", rx_overflow, 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ov_clr2", rx_overflow, 0);
    full = 1'b1;
    step(100);
    check("ov_nwr", wr_q.size() - wbase, 16);
    check("ov_first", wr_q[wbase], 8'h01);
    check("ov_last", wr_q[wbase+15], 8'h10);
    rx_enable = 1'b0;
    step(20);
    check("ov_npkt", pkt_cnt - pbase, 0);

    // 8-word packet is two full FX2 packets: no explicit commit.
    mark();
    send_pkt(8, 8'hA0, 8'h01);
    step(60);
    check("m8_nwr", wr_q.size() - wbase, 8);
    check("m8_last", wr_q[wbase+7], 8'hA7);
    check("m8_npkt", pkt_cnt - pbase, 0);

    // 5-word packet leaves one word in a short packet.
    mark();
    send_pkt(5, 8'hC0, 8'h01);
    step(60);
    check("m5_nwr", wr_q.size() - wbase, 5);
    check("m5_npkt", pkt_cnt - pbase, 1);
    check("m5_pkt_after", pkt_after - wbase, 5);

    // Host to bus read.
    mark();
    fx2_drv = 8'hA5;
    empty   = 1'b1;
    step(10);
    check("rd_valid", tx_valid, 1);
    check("rd_enable", tx_enable, 1);
    check("rd_data", tx_data, 8'hA5);
    check("rd_nrd", rd_cnt - rbase, 1);
    check("rd_sloe", sloe, 0);
    fx2_drv = 8'h5A;
    tx_read = 1'b1;
    step(1);
    tx_read = 1'b0;
    check("rd_consumed", tx_valid, 0);
    check("rd_hold", tx_data, 8'hA5);
    step(6);
    empty = 1'b0;
    check("rd2_nrd", rd_cnt - rbase, 2);
    check("rd2_data", tx_data, 8'h5A);
    check("rd2_valid", tx_valid, 1);
    tx_read = 1'b1;
    step(1);
    tx_read = 1'b0;

    // Reset in the middle of a write strobe.
    full = 1'b1;
    send_pkt(3, 8'h40, 8'h01);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (slwr === 1'b0) begin
        hit = 1'b1;
        break;
      end
    end
    check("rs_hit", hit, 1);
    reset = 1'b0;
    #1;
    check("rs_slwr", slwr, 1);
    check("rs_pkt_end", pkt_end, 1);
    check("rs_slrd", slrd, 1);
    check("rs_faddr", faddr, EP_OUT);
    check("rs_sloe", sloe, 0);
    step(2);
    mark();
    reset = 1'b1;
    step(30);
    check("rs_nwr", wr_q.size() - wbase, 0);
    check("rs_npkt", pkt_cnt - pbase, 0);

    check("no_overlap", overlap, 0);
    check("faddr_in_writes", bad_faddr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
